// File: rtl/out_memory_if.sv
// Bus bundle for the vector output memory: one 4-lane write port,
// a combinational 4-lane read port sharing the same address, and the
// registered base address of the most recent accepted write.
interface out_memory_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd1;
   logic [31:0] wd2;
   logic [31:0] wd3;
   logic [31:0] wd4;
   logic [31:0] last_addr;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] rd3;
   logic [31:0] rd4;

   // The datapath side drives address, enable and write data.
   modport master (
      output addr, we, wd1, wd2, wd3, wd4,
      input  last_addr, rd1, rd2, rd3, rd4
   );

   // The memory side consumes them and returns read data and last_addr.
   modport slave (
      input  addr, we, wd1, wd2, wd3, wd4,
      output last_addr, rd1, rd2, rd3, rd4
   );
endinterface

// File: rtl/out_memory.sv
// Output memory for the vector datapath. Each accepted write stores four
// 32-bit lanes at consecutive words starting at addr. Writes whose base
// would run past the end of the array are dropped; there is no wrap-around.
// The read port is combinational at the same addr and returns zeros when
// the base is out of range.
module out_memory #(
   parameter int DEPTH = 256
) (
   input logic        clk,
   input logic        rst,
   out_memory_if.slave bus
);

   localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] MAX_BASE = 32'(DEPTH - 4);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      mem_d [DEPTH];
   logic [31:0]      last_addr_q;
   logic [31:0]      last_addr_d;
   logic             in_range;
   logic [IDX_W-1:0] idx0;
   logic [IDX_W-1:0] idx1;
   logic [IDX_W-1:0] idx2;
   logic [IDX_W-1:0] idx3;

   // Range check on the full 32-bit address, then the four lane indices;
   // index truncation is safe because it is only used when in range.
   always_comb begin
      in_range = (bus.addr <= MAX_BASE);
      idx0     = bus.addr[IDX_W-1:0];
      idx1     = idx0 + IDX_W'(1);
      idx2     = idx0 + IDX_W'(2);
      idx3     = idx0 + IDX_W'(3);
   end

   // Next-state: an in-range write updates four words and last_addr,
   // anything else holds state.
   always_comb begin
      mem_d       = mem_q;
      last_addr_d = last_addr_q;
      if (bus.we && in_range) begin
         mem_d[idx0] = bus.wd1;
         mem_d[idx1] = bus.wd2;
         mem_d[idx2] = bus.wd3;
         mem_d[idx3] = bus.wd4;
         last_addr_d = bus.addr;
      end
   end

   // State registers; synchronous reset clears the whole array and wins
   // over a write presented on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         last_addr_q <= '0;
      end else begin
         mem_q       <= mem_d;
         last_addr_q <= last_addr_d;
      end
   end

   // Combinational read of the four words at addr, zero when out of range.
   always_comb begin
      bus.rd1       = in_range ? mem_q[idx0] : 32'd0;
      bus.rd2       = in_range ? mem_q[idx1] : 32'd0;
      bus.rd3       = in_range ? mem_q[idx2] : 32'd0;
      bus.rd4       = in_range ? mem_q[idx3] : 32'd0;
      bus.last_addr = last_addr_q;
   end

endmodule

// File: tb/tb_out_memory.sv
// Directed bench for out_memory: a reference memory model produces the
// expected read data and last_addr, each expectation is queued when the
// read is driven and popped and checked once the DUT output has settled.
module tb_out_memory;

   localparam int DEPTH = 256;

   typedef struct packed {
      logic [31:0] last_addr;
      logic [31:0] rd4;
      logic [31:0] rd3;
      logic [31:0] rd2;
      logic [31:0] rd1;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] exp_mem [DEPTH];
   logic [31:0] exp_last;
   exp_t        sb_q [$];
   int          compared;
   int          mismatched;

   out_memory_if bus ();

   out_memory #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one vector for a single rising edge and update the model the
   // way the memory is expected to behave on that edge.
   task automatic applyStimulus(input logic [31:0] a, input logic we,
                                input logic [31:0] w1, input logic [31:0] w2,
                                input logic [31:0] w3, input logic [31:0] w4);
      @(negedge clk);
      bus.addr = a;
      bus.we   = we;
      bus.wd1  = w1;
      bus.wd2  = w2;
      bus.wd3  = w3;
      bus.wd4  = w4;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
         exp_last = '0;
      end else if (we && a <= 32'(DEPTH - 4)) begin
         exp_mem[a]     = w1;
         exp_mem[a + 1] = w2;
         exp_mem[a + 2] = w3;
         exp_mem[a + 3] = w4;
         exp_last       = a;
      end
      #1;
      bus.we = 1'b0;
   endtask

   // Pop the oldest expectation and compare every output against it.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("[TB] FAIL %s scoreboard: observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         compared++;
         assert (bus.rd1 === e.rd1) else begin
            mismatched++;
            $error("[TB] FAIL %s rd1: observed=%0d expected=%0d", tag, bus.rd1, e.rd1);
         end
         compared++;
         assert (bus.rd2 === e.rd2) else begin
            mismatched++;
            $error("[TB] FAIL %s rd2: observed=%0d expected=%0d", tag, bus.rd2, e.rd2);
         end
         compared++;
         assert (bus.rd3 === e.rd3) else begin
            mismatched++;
            $error("[TB] FAIL %s rd3: observed=%0d expected=%0d", tag, bus.rd3, e.rd3);
         end
         compared++;
         assert (bus.rd4 === e.rd4) else begin
            mismatched++;
            $error("[TB] FAIL %s rd4: observed=%0d expected=%0d", tag, bus.rd4, e.rd4);
         end
         compared++;
         assert (bus.last_addr === e.last_addr) else begin
            mismatched++;
            $error("[TB] FAIL %s last_addr: observed=%0d expected=%0d",
                   tag, bus.last_addr, e.last_addr);
         end
      end
   endtask

   // Present a read address, queue the model's answer, then check it.
   task automatic readCheck(input logic [31:0] a, input string tag);
      exp_t e;
      @(negedge clk);
      bus.addr = a;
      bus.we   = 1'b0;
      e.last_addr = exp_last;
      if (a <= 32'(DEPTH - 4)) begin
         e.rd1 = exp_mem[a];
         e.rd2 = exp_mem[a + 1];
         e.rd3 = exp_mem[a + 2];
         e.rd4 = exp_mem[a + 3];
      end else begin
         e.rd1 = '0;
         e.rd2 = '0;
         e.rd3 = '0;
         e.rd4 = '0;
      end
      sb_q.push_back(e);
      #1;
      checkOutput(tag);
   endtask

   // Directed sequence.
   initial begin
      compared   = 0;
      mismatched = 0;
      exp_last   = '0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      rst      = 1'b1;
      bus.addr = '0;
      bus.we   = 1'b0;
      bus.wd1  = '0;
      bus.wd2  = '0;
      bus.wd3  = '0;
      bus.wd4  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      readCheck(32'd0, "reset_a0");
      readCheck(32'd4, "reset_a4");

      applyStimulus(32'd0, 1'b1, 32'd15, 32'd45, 32'd74, 32'd82);
      readCheck(32'd0, "single_write");
      repeat (10) @(posedge clk);
      readCheck(32'd0, "idle_hold");

      applyStimulus(32'd4, 1'b1, 32'd16, 32'd46, 32'd76, 32'd86);
      readCheck(32'd0, "second_a0");
      readCheck(32'd4, "second_a4");

      applyStimulus(32'd2, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4);
      applyStimulus(32'd3, 1'b1, 32'd9, 32'd9, 32'd9, 32'd9);
      readCheck(32'd0, "overlap_a0");
      readCheck(32'd4, "overlap_a4");

      applyStimulus(32'd253, 1'b1, 32'd111, 32'd222, 32'd333, 32'd444);
      readCheck(32'd0, "oor_253_a0");
      applyStimulus(32'd256, 1'b1, 32'd77, 32'd77, 32'd77, 32'd77);
      readCheck(32'd0, "oor_256_a0");
      applyStimulus(32'hFFFF_FFFC, 1'b1, 32'd55, 32'd55, 32'd55, 32'd55);
      readCheck(32'd0, "oor_huge_a0");
      applyStimulus(32'd252, 1'b1, 32'd1000, 32'd1001, 32'd1002, 32'd1003);
      readCheck(32'd252, "edge_252");
      readCheck(32'd253, "read_253");

      applyStimulus(32'd8, 1'b0, 32'd123, 32'd123, 32'd123, 32'd123);
      readCheck(32'd8, "we0_hold");

      applyStimulus(32'd8, 1'b1, 32'd100, 32'd101, 32'd102, 32'd103);
      readCheck(32'd8, "pre_reset_a8");
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(32'd8, 1'b1, 32'd50, 32'd51, 32'd52, 32'd53);
      @(negedge clk);
      rst = 1'b0;
      readCheck(32'd8, "reset_prio_a8");
      readCheck(32'd252, "reset_prio_a252");
      applyStimulus(32'd8, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8);
      readCheck(32'd8, "post_reset_a8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
